// File: rtl/cond_unit.sv
// cond_unit: ARM-style condition check with flag register and IT-style predicated blocks.
// Gated controls are combinational or registered depending on REG_OUT.
module cond_unit #(
   parameter int MAX_BLOCK = 4,
   parameter bit REG_OUT   = 1'b0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             InstrValid,
   input  logic                             Stall,
   input  logic                             Flush,
   input  logic [3:0]                       Cond,
   input  logic [3:0]                       ALUFlags,
   input  logic [1:0]                       FlagW,
   input  logic                             PCS,
   input  logic                             RegW,
   input  logic                             MemW,
   input  logic                             NoWrite,
   input  logic                             ItStart,
   input  logic [3:0]                       ItCond,
   input  logic [3:0]                       ItLen,
   input  logic [MAX_BLOCK-1:0]             ItPat,
   output logic                             PCSrc,
   output logic                             RegWrite,
   output logic                             MemWrite,
   output logic                             CondEx,
   output logic [3:0]                       Flags,
   output logic                             ItActive,
   output logic [$clog2(MAX_BLOCK+1)-1:0]   ItRemain
);
   localparam int RW = $clog2(MAX_BLOCK+1);
   localparam logic [3:0] MB4 = 4'(MAX_BLOCK);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t               state_q, state_d;
   logic [3:0]           flags_q, flags_d, itc_q, itc_d, eff_cond;
   logic [MAX_BLOCK-1:0] pat_q, pat_d;
   logic [RW-1:0]        rem_q, rem_d;
   logic                 accept, ce, gate, pcsrc_c, regw_c, memw_c;

   // Odd codes are the complement of the even code below them.
   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      {n, z, cf, v} = f;
      base = 1'b1;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf & ~z;
         3'd5: base = n == v;
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      return base ^ c[0];
   endfunction

   always_comb begin
      accept   = InstrValid & ~Stall;
      eff_cond = (state_q == ACTIVE) ? {itc_q[3:1], itc_q[0] ^ pat_q[0]} : Cond;
      ce       = InstrValid & (ItStart | cond_pass(eff_cond, flags_q));
      gate     = ce & ~ItStart;
      pcsrc_c  = PCS & gate;
      regw_c   = RegW & gate & ~NoWrite;
      memw_c   = MemW & gate;
   end

   always_comb begin
      state_d = state_q;
      flags_d = flags_q;
      itc_d   = itc_q;
      pat_d   = pat_q;
      rem_d   = rem_q;
      if (Flush) begin
         state_d = IDLE;
         pat_d   = '0;
         rem_d   = '0;
      end else if (accept) begin
         if (gate && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
         if (gate && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
         if (state_q == IDLE) begin
            if (ItStart && ItLen != 4'd0) begin
               state_d = ACTIVE;
               itc_d   = ItCond;
               pat_d   = ItPat;
               rem_d   = RW'(ItLen > MB4 ? MB4 : ItLen);
            end
         end else if (pcsrc_c || rem_q == RW'(1)) begin
            state_d = IDLE;
            pat_d   = '0;
            rem_d   = '0;
         end else begin
            pat_d = pat_q >> 1;
            rem_d = rem_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         flags_q <= '0;
         itc_q   <= '0;
         pat_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         itc_q   <= itc_d;
         pat_q   <= pat_d;
         rem_q   <= rem_d;
      end
   end

   assign Flags    = flags_q;
   assign ItActive = state_q == ACTIVE;
   assign ItRemain = rem_q;

   generate
      if (REG_OUT) begin : g_reg
         logic [3:0] out_q, out_d;
         assign out_d = {pcsrc_c, regw_c, memw_c, ce};
         always_ff @(posedge clk or posedge reset) begin
            if (reset) out_q <= '0;
            else if (Flush) out_q <= '0;
            else if (!Stall) out_q <= out_d;
         end
         assign {PCSrc, RegWrite, MemWrite, CondEx} = out_q;
      end else begin : g_comb
         assign {PCSrc, RegWrite, MemWrite, CondEx} = {pcsrc_c, regw_c, memw_c, ce};
      end
   endgenerate
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed and randomized checks of cond_unit, combinational and registered builds side by side.
module tb_cond_unit;
   logic clk, reset, InstrValid, Stall, Flush, PCS, RegW, MemW, NoWrite, ItStart;
   logic [3:0] Cond, ALUFlags, ItCond, ItLen, ItPat;
   logic [1:0] FlagW;
   logic c_pc, c_rw, c_mw, c_ce, c_act, r_pc, r_rw, r_mw, r_ce, r_act;
   logic [3:0] c_flags, r_flags;
   logic [2:0] c_rem, r_rem;
   int checks = 0, passes = 0;

   // reference model: flags, block active, base condition, pattern slots still to run
   logic [3:0] m_flags, m_itc, m_reg;
   logic m_act;
   logic pq[$];

   cond_unit #(.MAX_BLOCK(4), .REG_OUT(1'b0)) u_c (
      .clk(clk), .reset(reset), .InstrValid(InstrValid), .Stall(Stall), .Flush(Flush),
      .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
      .NoWrite(NoWrite), .ItStart(ItStart), .ItCond(ItCond), .ItLen(ItLen), .ItPat(ItPat),
      .PCSrc(c_pc), .RegWrite(c_rw), .MemWrite(c_mw), .CondEx(c_ce), .Flags(c_flags),
      .ItActive(c_act), .ItRemain(c_rem));

   cond_unit #(.MAX_BLOCK(4), .REG_OUT(1'b1)) u_r (
      .clk(clk), .reset(reset), .InstrValid(InstrValid), .Stall(Stall), .Flush(Flush),
      .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
      .NoWrite(NoWrite), .ItStart(ItStart), .ItCond(ItCond), .ItLen(ItLen), .ItPat(ItPat),
      .PCSrc(r_pc), .RegWrite(r_rw), .MemWrite(r_mw), .CondEx(r_ce), .Flags(r_flags),
      .ItActive(r_act), .ItRemain(r_rem));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic pass_f(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cf;
         4'h3: return !cf;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cf && !z;
         4'h9: return !(cf && !z);
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && n == v;
         4'hD: return !(!z && n == v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // expected {PCSrc, RegWrite, MemWrite, CondEx} for the current inputs
   function automatic logic [3:0] comb_f();
      logic [3:0] ec;
      logic ce, g;
      ec = m_act ? {m_itc[3:1], m_itc[0] ^ (pq.size() > 0 ? pq[0] : 1'b0)} : Cond;
      ce = InstrValid && (ItStart || pass_f(ec, m_flags));
      g = ce && !ItStart;
      return {PCS && g, RegW && g && !NoWrite, MemW && g, ce};
   endfunction

   task automatic mreset();
      m_flags = 4'h0;
      m_itc = 4'h0;
      m_reg = 4'h0;
      m_act = 1'b0;
      pq.delete();
   endtask

   task automatic clr();
      {InstrValid, Stall, Flush, PCS, RegW, MemW, NoWrite, ItStart} = '0;
      {Cond, ALUFlags, ItCond, ItLen, ItPat, FlagW} = '0;
   endtask

   task automatic tick();
      logic [3:0] c;
      logic acc;
      c = comb_f();
      acc = InstrValid && !Stall;
      @(posedge clk);
      if (Flush) begin
         m_act = 1'b0;
         pq.delete();
         m_reg = 4'h0;
      end else begin
         if (!Stall) m_reg = c;
         if (acc) begin
            if (c[0] && !ItStart && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
            if (c[0] && !ItStart && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
            if (!m_act) begin
               if (ItStart && ItLen != 0) begin
                  m_act = 1'b1;
                  m_itc = ItCond;
                  for (int i = 0; i < (ItLen > 4 ? 4 : int'(ItLen)); i++) pq.push_back(ItPat[i]);
               end
            end else begin
               void'(pq.pop_front());
               if (c[3] || pq.size() == 0) begin
                  m_act = 1'b0;
                  pq.delete();
               end
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic set_flags(input logic [3:0] f);
      clr();
      InstrValid = 1'b1;
      Cond = 4'hE;
      FlagW = 2'b11;
      ALUFlags = f;
      tick();
      clr();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clr();
      mreset();
      #2;
      checks++;
      if ({c_flags, c_act, c_rem} !== 8'h0) $display("FAIL reset_c state got %h want 00", {c_flags, c_act, c_rem});
      else passes++;
      checks++;
      if ({r_flags, r_act, r_rem, r_pc, r_rw, r_mw, r_ce} !== 12'h0)
         $display("FAIL reset_r state got %h want 000", {r_flags, r_act, r_rem, r_pc, r_rw, r_mw, r_ce});
      else passes++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_cond_eq();
      set_flags(4'b0100);
      InstrValid = 1'b1;
      RegW = 1'b1;
      Cond = 4'h0;
      #1;
      checks++;
      if (c_rw !== 1'b1) $display("FAIL cond_eq RegWrite got %b want 1", c_rw);
      else passes++;
      Cond = 4'h1;
      #1;
      checks++;
      if (c_rw !== 1'b0) $display("FAIL cond_ne RegWrite got %b want 0", c_rw);
      else passes++;
      NoWrite = 1'b1;
      Cond = 4'h0;
      #1;
      checks++;
      if (c_rw !== 1'b0) $display("FAIL nowrite RegWrite got %b want 0", c_rw);
      else passes++;
      tick();
      clr();
   endtask

   task automatic test_flag_write();
      set_flags(4'b0000);
      InstrValid = 1'b1;
      Cond = 4'hE;
      FlagW = 2'b10;
      ALUFlags = 4'b1011;
      #1;
      checks++;
      if (c_flags !== 4'b0000) $display("FAIL flags_same_cycle got %b want 0000", c_flags);
      else passes++;
      tick();
      checks++;
      if (c_flags !== 4'b1000) $display("FAIL flagw_nz got %b want 1000", c_flags);
      else passes++;
      FlagW = 2'b01;
      ALUFlags = 4'b0011;
      tick();
      checks++;
      if (c_flags !== 4'b1011) $display("FAIL flagw_cv got %b want 1011", c_flags);
      else passes++;
      clr();
   endtask

   task automatic test_block();
      logic [3:0] rw_exp, rem_exp;
      set_flags(4'b0100);
      InstrValid = 1'b1;
      ItStart = 1'b1;
      ItCond = 4'h0;
      ItLen = 4'd3;
      ItPat = 4'b0010;
      RegW = 1'b1;
      #1;
      checks++;
      if ({c_rw, c_ce} !== 2'b01) $display("FAIL it_start gated got %b want 01", {c_rw, c_ce});
      else passes++;
      tick();
      ItStart = 1'b0;
      rw_exp = 4'b0101;
      rem_exp = 4'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({c_rw, c_act, c_rem} !== {rw_exp[i], 1'b1, rem_exp[2:0]})
            $display("FAIL block_slot%0d got rw/act/rem %b want %b", i, {c_rw, c_act, c_rem}, {rw_exp[i], 1'b1, rem_exp[2:0]});
         else passes++;
         tick();
         rem_exp = rem_exp - 1;
      end
      checks++;
      if ({c_act, c_rem} !== 4'b0000) $display("FAIL block_end got act/rem %b want 0000", {c_act, c_rem});
      else passes++;
      clr();
   endtask

   task automatic test_stall_flush();
      InstrValid = 1'b1;
      ItStart = 1'b1;
      ItCond = 4'hE;
      ItLen = 4'd4;
      tick();
      ItStart = 1'b0;
      RegW = 1'b1;
      tick();
      Stall = 1'b1;
      RegW = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({r_rw, r_rem, c_rem} !== 7'b1_011_011)
            $display("FAIL stall%0d got rw/rem_r/rem_c %b want 1011011", i, {r_rw, r_rem, c_rem});
         else passes++;
      end
      Stall = 1'b0;
      RegW = 1'b1;
      tick();
      Flush = 1'b1;
      tick();
      checks++;
      if ({c_act, c_rem, r_act, r_rem, r_pc, r_rw, r_mw, r_ce} !== 12'h0)
         $display("FAIL flush got %h want 000", {c_act, c_rem, r_act, r_rem, r_pc, r_rw, r_mw, r_ce});
      else passes++;
      clr();
   endtask

   task automatic test_never();
      set_flags(4'b0100);
      InstrValid = 1'b1;
      Cond = 4'hF;
      PCS = 1'b1;
      FlagW = 2'b11;
      ALUFlags = 4'b1111;
      #1;
      checks++;
      if ({c_pc, c_ce} !== 2'b00) $display("FAIL never PCSrc/CondEx got %b want 00", {c_pc, c_ce});
      else passes++;
      tick();
      checks++;
      if (c_flags !== 4'b0100) $display("FAIL never_flags got %b want 0100", c_flags);
      else passes++;
      clr();
   endtask

   task automatic test_edge_cases();
      InstrValid = 1'b1;
      ItStart = 1'b1;
      ItLen = 4'd0;
      tick();
      checks++;
      if ({c_act, c_rem} !== 4'b0000) $display("FAIL itlen0 got act/rem %b want 0000", {c_act, c_rem});
      else passes++;
      ItCond = 4'hE;
      ItLen = 4'd9;
      tick();
      checks++;
      if ({c_act, c_rem} !== 4'b1100) $display("FAIL itlen_clamp got act/rem %b want 1100", {c_act, c_rem});
      else passes++;
      ItStart = 1'b0;
      PCS = 1'b1;
      #1;
      checks++;
      if (c_pc !== 1'b1) $display("FAIL block_branch PCSrc got %b want 1", c_pc);
      else passes++;
      tick();
      checks++;
      if ({c_act, c_rem} !== 4'b0000) $display("FAIL branch_exit got act/rem %b want 0000", {c_act, c_rem});
      else passes++;
      clr();
   endtask

   task automatic test_async_reset();
      set_flags(4'b1010);
      InstrValid = 1'b1;
      ItStart = 1'b1;
      ItCond = 4'hE;
      ItLen = 4'd4;
      tick();
      ItStart = 1'b0;
      tick();
      tick();
      checks++;
      if ({c_act, c_rem, c_flags} !== 8'b1_010_1010) $display("FAIL pre_reset got %b want 10101010", {c_act, c_rem, c_flags});
      else passes++;
      clr();
      reset = 1'b1;
      #1;
      checks++;
      if ({c_flags, c_act, c_rem, r_flags, r_act} !== 13'h0)
         $display("FAIL async_reset got %h want 0000", {c_flags, c_act, c_rem, r_flags, r_act});
      else passes++;
      mreset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({c_act, c_rem} !== 4'b0000) $display("FAIL post_reset got %b want 0000", {c_act, c_rem});
      else passes++;
   endtask

   task automatic test_random();
      logic [3:0] e;
      for (int n = 0; n < 300; n++) begin
         InstrValid = $urandom_range(0, 9) != 0;
         Stall = $urandom_range(0, 3) == 0;
         Flush = $urandom_range(0, 24) == 0;
         Cond = 4'($urandom);
         ALUFlags = 4'($urandom);
         FlagW = 2'($urandom);
         {PCS, RegW, MemW} = 3'($urandom);
         PCS = PCS && ($urandom_range(0, 3) == 0);
         NoWrite = $urandom_range(0, 4) == 0;
         ItStart = $urandom_range(0, 5) == 0;
         ItCond = 4'($urandom_range(0, 14));
         ItLen = 4'($urandom_range(0, 6));
         ItPat = 4'($urandom);
         #1;
         e = comb_f();
         checks++;
         if ({c_pc, c_rw, c_mw, c_ce} !== e) $display("FAIL rand%0d comb got %b want %b", n, {c_pc, c_rw, c_mw, c_ce}, e);
         else passes++;
         checks++;
         if ({c_flags, c_act, c_rem} !== {m_flags, m_act, 3'(pq.size())})
            $display("FAIL rand%0d state_c got %b want %b", n, {c_flags, c_act, c_rem}, {m_flags, m_act, 3'(pq.size())});
         else passes++;
         checks++;
         if ({r_flags, r_act, r_rem, r_pc, r_rw, r_mw, r_ce} !== {m_flags, m_act, 3'(pq.size()), m_reg})
            $display("FAIL rand%0d state_r got %b want %b", n, {r_flags, r_act, r_rem, r_pc, r_rw, r_mw, r_ce},
                     {m_flags, m_act, 3'(pq.size()), m_reg});
         else passes++;
         tick();
      end
      clr();
   endtask

   initial begin
      test_reset();
      test_cond_eq();
      test_flag_write();
      test_block();
      test_stall_flush();
      test_never();
      test_edge_cases();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
